ws2812_frame_sequencer: RTL
===========================

# ws2812_frame_sequencer

Upstream stage of `ws2812_driver`. It holds a double-buffered GRB frame that pixel writers fill one LED at a time, and applies global brightness scaling on write. It launches a driver transfer whenever a frame is committed or the refresh interval expires. It replaces the free-running start loop in the top level, and its `drv_*` ports connect directly to the driver's `start`/`data`/`busy`.

## Interface
- `LED_COUNT`, 8, number of LEDs in the chain.
- `REFRESH_CYCLES`, 1_000_000, clk cycles between automatic retransmissions of the front buffer (≥ 16).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `wr_en` in 1: pixel write strobe.
- `wr_addr` in $clog2(LED_COUNT): LED index; 0 is the first LED in the chain (MS 24 bits of `drv_data`).
- `wr_grb` in 24: pixel colour, G[23:16] R[15:8] B[7:0].
- `brightness` in 8: global scale applied at write time.
- `commit` in 1: single-cycle request to publish the back buffer.
- `pending` out 1: commit accepted, not yet launched.
- `drv_busy` in 1: driver busy.
- `drv_start` out 1: one-cycle start pulse to the driver.
- `drv_data` out LED_COUNT*24: front buffer, stable while the driver is busy.
- `frame_count` out 16: launches since reset, wraps at 0xFFFF→0.

## Operation
- **Write:** when `wr_en` is high and `wr_addr < LED_COUNT`, the back buffer slot is set to the scaled colour. Out-of-range addresses are ignored.
- **Scaling:** per channel, `out = (ch * (brightness + 1)) >> 8`, using a 16-bit product and keeping the upper 8 bits. `brightness` = 255 is the identity; `brightness` = 0 gives `ch >> 8` = 0.
- **Commit:** `commit` sets `pending`. A commit while already pending has no additional effect.
- **FSM states:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE → LAUNCH when `drv_busy` = 0 and (`pending` or refresh timer expired).
  - LAUNCH (1 cycle):
    - `drv_start` = 1.
    - If `pending`, copy back → front (pre-edge back contents) and clear `pending`. Otherwise the front buffer is unchanged (retransmit).
    - `frame_count` += 1; refresh timer cleared.
    - → WAIT_BUSY.
  - WAIT_BUSY: → WAIT_DONE when `drv_busy` = 1. If `drv_busy` is not seen within 2 cycles, → IDLE (guard against a zero-length transfer).
  - WAIT_DONE: → IDLE when `drv_busy` = 0.
- **Refresh timer:** counts 0..REFRESH_CYCLES-1 in every state except LAUNCH. It holds "expired" at REFRESH_CYCLES-1 until the next launch.

## Timing
- **Reset values:** `drv_start` 0, `drv_data` all 0 (LEDs off), `pending` 0, `frame_count` 0, back buffer 0, timer 0, state IDLE.
- **Commit to start latency:** `commit` at edge N with driver idle and FSM in IDLE → `pending` high after N. LAUNCH at N+1 → `drv_start` high in the cycle after edge N+1. `drv_data` shows the new frame from edge N+2.
- **`drv_data`:** changes only on LAUNCH exit, i.e. only when the driver is idle.
- **Simultaneous events:**
  - Write at the LAUNCH copy edge: the copy takes the old value; the write lands in the back buffer for the next frame.
  - `commit` in the LAUNCH cycle: `pending` is cleared by the copy and re-set by the commit, so `pending` = 1 after the edge.
  - `pending` and timer expiry together: a single launch carrying the new frame.
- **Reset mid-transfer:** outputs return to reset values immediately. The driver is reset independently; after reset deassertion, the first launch occurs only on commit or after a full refresh interval.

## Structure
- Shared package `ws2812_pkg`:
  - `GRB_W` = 24.
  - Channel field offsets.
  - FSM state typedef.
  - `BUSY_GUARD_CYCLES` = 2.
- Sub-module `ws2812_scale`: combinational 24-bit GRB × brightness scaler, three 8×9 multiplies.
- Buffers are flat `LED_COUNT*24` registers; `LED_COUNT` is small, so no RAM.

## Test plan
- **Reset:** assert `reset` asynchronously mid-WAIT_DONE → `drv_start` = 0, `drv_data` = 0, `frame_count` = 0 the same cycle.
- **Basic write/commit:** `brightness` = 255; write 0xFF0000 @0 and 0x0000FF @7; commit → exactly one `drv_start` pulse. `drv_data[191:168]` = 0xFF0000, `drv_data[23:0]` = 0x0000FF, `frame_count` = 1.
- **Scaling:** `brightness` = 127; write 0x80FF40 @3; commit → slot 3 = 0x407F20. `brightness` = 0 → 0x000000.
- **Busy interlock:** hold `drv_busy` = 1 and commit → no `drv_start` and `pending` = 1; release → start one cycle later. Writing 0x00FF00 @1 during WAIT_DONE leaves `drv_data` unchanged.
- **Refresh:** `REFRESH_CYCLES` = 16, no commits → `drv_start` every 16 non-LAUNCH cycles plus the transfer time; `drv_data` unchanged; `frame_count` increments each time.
- **Edge cases:**
  - Write to `wr_addr` = LED_COUNT (non-power-of-2 build, `LED_COUNT` = 6) → ignored.
  - Commit in the LAUNCH cycle → `pending` = 1 afterwards and a second launch follows.
  - `frame_count` preset near 0xFFFF wraps to 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared constants and FSM state type for the ws2812 frame path
// Contents:
//   GRB_W              pixel width in bits (G[23:16] R[15:8] B[7:0])
//   G_OFS/R_OFS/B_OFS  channel bit offsets inside a GRB word
//   CH_W               channel width
//   BUSY_GUARD_CYCLES  cycles to wait for the driver to raise busy after a start
//   seq_state_e        frame sequencer FSM states
package ws2812_pkg;

  localparam int GRB_W             = 24;
  localparam int CH_W              = 8;
  localparam int G_OFS             = 16;
  localparam int R_OFS             = 8;
  localparam int B_OFS             = 0;
  localparam int BUSY_GUARD_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ws2812_scale.sv
// rtl/ws2812_scale.sv - combinational GRB brightness scaler
// Ports:
//   i_grb        input pixel, G[23:16] R[15:8] B[7:0]
//   i_brightness global scale; 255 is identity, 0 blanks the pixel
//   o_grb        scaled pixel, each channel = (ch * (brightness + 1)) >> 8
module ws2812_scale
  import ws2812_pkg::*;
(
  input  logic [GRB_W-1:0] i_grb,
  input  logic [7:0]       i_brightness,
  output logic [GRB_W-1:0] o_grb
);

  // brightness + 1 needs 9 bits so that 255 maps to x256 (exact identity)
  logic [8:0] w_mult;
  assign w_mult = {1'b0, i_brightness} + 9'd1;

  // 255 * 256 = 65280 still fits the 16-bit product
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch, input logic [8:0] m);
    logic [15:0] p;
    p = 16'(ch) * 16'(m);
    return CH_W'(p >> 8);
  endfunction

  assign o_grb = {scale_ch(i_grb[G_OFS +: CH_W], w_mult),
                  scale_ch(i_grb[R_OFS +: CH_W], w_mult),
                  scale_ch(i_grb[B_OFS +: CH_W], w_mult)};

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// rtl/ws2812_frame_sequencer.sv - double-buffered GRB frame store and ws2812 launch sequencer
// Ports:
//   i_clk, i_reset     clock, asynchronous active-high reset
//   i_wr_en/i_wr_addr  pixel write strobe and LED index (0 = first LED, MS bits of o_drv_data)
//   i_wr_grb           pixel colour, scaled by i_brightness before it is stored
//   i_commit           request to publish the back buffer; o_pending holds it until launch
//   i_drv_busy         driver busy
//   o_drv_start        one-cycle start pulse to the driver
//   o_drv_data         front buffer, only changes while the driver is idle
//   o_frame_count      number of launches since reset (wraps)
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter  int LED_COUNT      = 8,
  parameter  int REFRESH_CYCLES = 1_000_000,
  localparam int AW             = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1,
  localparam int FW             = LED_COUNT * GRB_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [GRB_W-1:0] i_wr_grb,
  input  logic [7:0]       i_brightness,
  input  logic             i_commit,
  output logic             o_pending,
  input  logic             i_drv_busy,
  output logic             o_drv_start,
  output logic [FW-1:0]    o_drv_data,
  output logic [15:0]      o_frame_count
);

  localparam int             TW         = $clog2(REFRESH_CYCLES);
  localparam logic [TW-1:0]  TIMER_MAX  = TW'(REFRESH_CYCLES - 1);
  localparam int             GW         = (BUSY_GUARD_CYCLES > 1) ? $clog2(BUSY_GUARD_CYCLES) : 1;
  localparam logic [GW-1:0]  GUARD_LAST = GW'(BUSY_GUARD_CYCLES - 1);

  seq_state_e       r_state;
  seq_state_e       w_next_state;
  logic [FW-1:0]    r_front;
  logic [FW-1:0]    r_back;
  logic             r_pending;
  logic             r_drv_start;
  logic [15:0]      r_frame_count;
  logic [TW-1:0]    r_timer;
  logic [GW-1:0]    r_guard;
  logic [GRB_W-1:0] w_scaled;
  logic             w_expired;
  logic             w_launch;

  ws2812_scale u_scale (
    .i_grb        (i_wr_grb),
    .i_brightness (i_brightness),
    .o_grb        (w_scaled)
  );

  assign w_expired = (r_timer == TIMER_MAX);
  assign w_launch  = (r_state == ST_LAUNCH);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (!i_drv_busy && (r_pending || w_expired)) w_next_state = ST_LAUNCH;
      ST_LAUNCH:    w_next_state = ST_WAIT_BUSY;
      // a driver that never raises busy (zero-length transfer) must not hang us here
      ST_WAIT_BUSY: if (i_drv_busy) w_next_state = ST_WAIT_DONE;
                    else if (r_guard == GUARD_LAST) w_next_state = ST_IDLE;
      ST_WAIT_DONE: if (!i_drv_busy) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_drv_start   <= 1'b0;
      r_pending     <= 1'b0;
      r_front       <= '0;
      r_frame_count <= '0;
      r_timer       <= '0;
      r_guard       <= '0;
    end else begin
      r_state     <= w_next_state;
      // registered so the pulse coincides exactly with the LAUNCH cycle
      r_drv_start <= (w_next_state == ST_LAUNCH);
      // a commit in the LAUNCH cycle wins over the clear, queueing another frame
      if (i_commit)      r_pending <= 1'b1;
      else if (w_launch) r_pending <= 1'b0;
      if (w_launch && r_pending) r_front <= r_back;
      if (w_launch) r_frame_count <= r_frame_count + 16'd1;
      if (w_launch)        r_timer <= '0;
      else if (!w_expired) r_timer <= r_timer + 1'b1;
      if (r_state == ST_WAIT_BUSY) r_guard <= r_guard + 1'b1;
      else                         r_guard <= '0;
    end
  end

  // out-of-range addresses match no slot and are dropped
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_back <= '0;
    end else begin
      for (int i = 0; i < LED_COUNT; i++) begin
        if (i_wr_en && (i_wr_addr == AW'(i)))
          r_back[(LED_COUNT - 1 - i) * GRB_W +: GRB_W] <= w_scaled;
      end
    end
  end

  assign o_pending     = r_pending;
  assign o_drv_start   = r_drv_start;
  assign o_drv_data    = r_front;
  assign o_frame_count = r_frame_count;

endmodule
